pe_rx_checker: RTL and testbench
================================

# pe_rx_checker

Receive-side traffic checker attached to each processing-element port of the mesh, directly downstream of the mesh egress. Consumes every packet the mesh delivers to tile (xcord, ycord), checks destination address and per-source sequence ordering, and accumulates received-packet count and latency statistics. Raises `done` once the expected packet count has arrived, so the bench can AND per-tile `done` flags into a global end-of-test.

## Interface
- xcord, 0, X coordinate of this tile
- ycord, 0, Y coordinate of this tile
- X, 2, mesh columns
- Y, 2, mesh rows
- data_width, 256, payload width; must be ≥ 56
- x_size, 1, destination-X field width
- y_size, 1, destination-Y field width
- total_width, x_size+y_size+data_width, flit width
- num_expected, 100, packets this tile must receive before `done`

- clk  in  1  single clock; all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- i_valid  in  1  flit from mesh egress valid; no backpressure, accepted every cycle it is high
- i_data  in  total_width  flit from mesh egress
- done  out  1  sticky; expected count reached
- err  out  1  sticky OR of err_flags
- err_flags  out  3  sticky {overflow, seq_err, addr_err}
- rx_count  out  32  packets accepted
- lat_max  out  32  maximum observed latency, cycles
- lat_sum  out  48  sum of latencies, saturating at all-ones

## Operation
- Flit layout: [x_size-1:0] dest X; [x_size+y_size-1:x_size] dest Y; payload above. Payload bits [15:0] seq, [23:16] src id (= sx + X·sy), [55:24] injection timestamp.
- Free-running 32-bit cycle counter, reset to 0, +1 every cycle, wraps. Injectors use an identically reset counter.
- State machine: IDLE (no packet yet) → RUN on first accepted flit → DONE when rx_count reaches num_expected. DONE is left only by reset.
- Per accepted flit (i_valid=1):
  - addr_err set if dest X ≠ xcord or dest Y ≠ ycord; flit still counted.
  - src id ≥ X·Y: addr_err set; no sequence-table update.
  - seq_err set if seq ≠ exp[src]; then exp[src] ← seq+1 (mod 2^16), resynchronising after a gap.
  - latency = cycle_cnt − timestamp, modulo 2^32 (wrap-safe).
  - lat_max ← max(lat_max, latency); lat_sum ← lat_sum + latency, saturating.
  - rx_count +1 (wraps at 2^32, not reachable in practice).
  - In DONE: overflow set; stats still update.
- exp[] table: X·Y entries × 16 bits, all 0 at reset.

## Timing
- Reset values: done=0, err=0, err_flags=0, rx_count=0, lat_max=0, lat_sum=0, state IDLE, cycle_cnt=0.
- Flit sampled at edge N; all outputs reflect it after edge N (one-cycle latency). done rises the cycle after the num_expected-th flit.
- Back-to-back flits from the same source every cycle: exp[] read-before-write on the same edge; the second flit sees the updated value. No bubbles required.
- Reset asserted mid-run clears everything immediately (asynchronous); flit present in the reset-deassert cycle is accepted normally.
- num_expected = 0: done asserts the first cycle after reset release; any flit then sets overflow.

## Structure
- Shared package noc_pkt_pkg: field offsets/widths (SEQ_LSB, SRC_LSB, TS_LSB, SEQ_W=16, SRC_W=8, TS_W=32) and the src-id formula, reused by the traffic generators.
- One sub-module: rx_seq_table (X·Y×16 register file, one combinational read port, one write port, async reset).

## Test plan
- Reset, then 3 flits from src 1 with seq 0,1,2, dest = tile, timestamps 10,11,12 arriving at cycles 20,21,22 → rx_count=3, lat_max=10, lat_sum=30, err=0.
- Flit with dest X ≠ xcord → err_flags=3'b001 next cycle, rx_count still +1.
- Src 2 sends seq 0 then seq 2 → seq_err set; following seq 3 raises no new error (table resynchronised).
- Timestamp 0xFFFF_FFF0 received when cycle_cnt=0x0000_0005 → latency 21 recorded.
- num_expected=4: four flits → done high cycle after fourth; fifth flit → overflow set, rx_count=5.
- Assert rstn low mid-stream after 2 flits → all outputs 0 immediately; restart from seq 0 without seq_err.

Source files
------------

// File: rtl/noc_pkt_pkg.sv
// rtl/noc_pkt_pkg.sv - packet payload field layout shared by the mesh checkers and traffic generators
package noc_pkt_pkg;

    localparam int SEQ_LSB = 0;
    localparam int SEQ_W   = 16;
    localparam int SRC_LSB = 16;
    localparam int SRC_W   = 8;
    localparam int TS_LSB  = 24;
    localparam int TS_W    = 32;
    localparam int HDR_W   = TS_LSB + TS_W;

    localparam int ERR_ADDR = 0;
    localparam int ERR_SEQ  = 1;
    localparam int ERR_OVF  = 2;

    // Field order matches SEQ_LSB/SRC_LSB/TS_LSB from the bottom of the payload.
    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [SRC_W-1:0] src;
        logic [SEQ_W-1:0] seq;
    } pkt_hdr_t;

    function automatic int src_id(input int sx, input int sy, input int x_cols);
        return sx + x_cols * sy;
    endfunction

endpackage

// File: rtl/pe_rx_checker_if.sv
// rtl/pe_rx_checker_if.sv - mesh egress flit stream into a tile checker
interface pe_rx_checker_if #(
    parameter int TOTAL_W = 258
);
    logic               i_valid;
    logic [TOTAL_W-1:0] i_data;

    modport master (output i_valid, output i_data);
    modport slave  (input  i_valid, input  i_data);
endinterface

// File: rtl/rx_seq_table.sv
// rtl/rx_seq_table.sv - per-source expected sequence number register file
module rx_seq_table
    import noc_pkt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [SEQ_W-1:0] rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [SEQ_W-1:0] wr_data
);

    logic [SEQ_W-1:0] mem_q [DEPTH];
    logic [SEQ_W-1:0] mem_d [DEPTH];

    // Out-of-range indices (non power-of-two DEPTH) read as zero and never write.
    always_comb begin
        rd_data = '0;
        if (32'(rd_idx) < 32'(DEPTH)) begin
            rd_data = mem_q[rd_idx];
        end
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en && (32'(wr_idx) < 32'(DEPTH))) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/pe_rx_checker.sv
// rtl/pe_rx_checker.sv - per-tile receive checker: address, sequence order, latency stats, done
module pe_rx_checker
    import noc_pkt_pkg::*;
#(
    parameter int xcord        = 0,
    parameter int ycord        = 0,
    parameter int X            = 2,
    parameter int Y            = 2,
    parameter int data_width   = 256,
    parameter int x_size       = 1,
    parameter int y_size       = 1,
    parameter int total_width  = x_size + y_size + data_width,
    parameter int num_expected = 100
) (
    input  logic             clk,
    input  logic             rstn,
    pe_rx_checker_if.slave   rx,
    output logic             done,
    output logic             err,
    output logic [2:0]       err_flags,
    output logic [31:0]      rx_count,
    output logic [31:0]      lat_max,
    output logic [47:0]      lat_sum
);

    localparam int NSRC  = X * Y;
    localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] rx_count_q, rx_count_d;
    logic [31:0] lat_max_q, lat_max_d;
    logic [47:0] lat_sum_q, lat_sum_d;
    logic [2:0]  err_flags_q, err_flags_d;

    logic [x_size-1:0] dest_x;
    logic [y_size-1:0] dest_y;
    pkt_hdr_t          hdr;
    logic              src_ok;
    logic [IDX_W-1:0]  src_idx;
    logic [SEQ_W-1:0]  exp_seq;
    logic [31:0]       latency;
    logic [48:0]       sum_ext;

    assign dest_x  = rx.i_data[x_size-1:0];
    assign dest_y  = rx.i_data[x_size+y_size-1:x_size];
    assign hdr     = rx.i_data[x_size+y_size +: HDR_W];
    assign src_ok  = 32'(hdr.src) < 32'(NSRC);
    assign src_idx = IDX_W'(hdr.src);
    assign latency = cycle_cnt_q - hdr.ts;
    assign sum_ext = {1'b0, lat_sum_q} + {17'b0, latency};

    // Combinational read sees the pre-edge value, so back-to-back flits from one source chain correctly.
    rx_seq_table #(
        .DEPTH (NSRC),
        .IDX_W (IDX_W)
    ) u_seq_table (
        .clk     (clk),
        .rstn    (rstn),
        .rd_idx  (src_idx),
        .rd_data (exp_seq),
        .wr_en   (rx.i_valid && src_ok),
        .wr_idx  (src_idx),
        .wr_data (hdr.seq + 16'd1)
    );

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        rx_count_d  = rx_count_q;
        lat_max_d   = lat_max_q;
        lat_sum_d   = lat_sum_q;
        err_flags_d = err_flags_q;
        state_d     = state_q;

        if (rx.i_valid) begin
            rx_count_d = rx_count_q + 32'd1;
            if (latency > lat_max_q) begin
                lat_max_d = latency;
            end
            lat_sum_d = sum_ext[48] ? '1 : sum_ext[47:0];
            if ((dest_x != x_size'(xcord)) || (dest_y != y_size'(ycord)) || !src_ok) begin
                err_flags_d[ERR_ADDR] = 1'b1;
            end
            if (src_ok && (hdr.seq != exp_seq)) begin
                err_flags_d[ERR_SEQ] = 1'b1;
            end
            if (state_q == ST_DONE) begin
                err_flags_d[ERR_OVF] = 1'b1;
            end
        end

        // A zero target count means DONE is reached on the very first edge after reset.
        if (state_q != ST_DONE) begin
            if (rx_count_d >= 32'(num_expected)) begin
                state_d = ST_DONE;
            end else if (rx.i_valid) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cycle_cnt_q <= '0;
            rx_count_q  <= '0;
            lat_max_q   <= '0;
            lat_sum_q   <= '0;
            err_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            rx_count_q  <= rx_count_d;
            lat_max_q   <= lat_max_d;
            lat_sum_q   <= lat_sum_d;
            err_flags_q <= err_flags_d;
        end
    end

    assign done      = (state_q == ST_DONE);
    assign err       = |err_flags_q;
    assign err_flags = err_flags_q;
    assign rx_count  = rx_count_q;
    assign lat_max   = lat_max_q;
    assign lat_sum   = lat_sum_q;

endmodule

// File: tb/tb_pe_rx_checker.sv
// tb/tb_pe_rx_checker.sv - randomized and directed bench for pe_rx_checker against a behavioural model
module tb_pe_rx_checker;

    localparam int DW = 64;
    localparam int TW = 2 + DW;
    localparam int NA = 40;
    localparam int NB = 4;
    localparam int NC = 0;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pe_rx_checker_if #(.TOTAL_W(TW)) rx_if ();

    logic        done_a, err_a, done_b, err_b, done_c, err_c;
    logic [2:0]  flags_a, flags_b, flags_c;
    logic [31:0] rxc_a, rxc_b, rxc_c, lmax_a, lmax_b, lmax_c;
    logic [47:0] lsum_a, lsum_b, lsum_c;

    pe_rx_checker #(.data_width(DW), .num_expected(NA)) dut_a (
        .clk(clk), .rstn(rstn), .rx(rx_if.slave), .done(done_a), .err(err_a), .err_flags(flags_a),
        .rx_count(rxc_a), .lat_max(lmax_a), .lat_sum(lsum_a));
    pe_rx_checker #(.data_width(DW), .num_expected(NB)) dut_b (
        .clk(clk), .rstn(rstn), .rx(rx_if.slave), .done(done_b), .err(err_b), .err_flags(flags_b),
        .rx_count(rxc_b), .lat_max(lmax_b), .lat_sum(lsum_b));
    pe_rx_checker #(.data_width(DW), .num_expected(NC)) dut_c (
        .clk(clk), .rstn(rstn), .rx(rx_if.slave), .done(done_c), .err(err_c), .err_flags(flags_c),
        .rx_count(rxc_c), .lat_max(lmax_c), .lat_sum(lsum_c));

    int errors = 0;
    int checks = 0;

    logic [31:0] m_cnt, m_rx, m_lmax;
    logic [47:0] m_lsum;
    logic        m_addr, m_seq;
    logic [2:0]  m_ovf;
    logic [15:0] m_exp [4];
    int          m_edges;
    int          n_exp [3] = '{NA, NB, NC};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk(input logic dx, input logic dy, input logic [7:0] src,
                                         input logic [15:0] seq, input logic [31:0] ts);
        logic [TW-1:0] d;
        d = '0;
        d[0] = dx;
        d[1] = dy;
        d[2 +: 16] = seq;
        d[18 +: 8] = src;
        d[26 +: 32] = ts;
        d[58 +: 8] = 8'($urandom);
        return d;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_rx = 0; m_lmax = 0; m_lsum = 0;
        m_addr = 0; m_seq = 0; m_ovf = 0; m_edges = 0;
        for (int i = 0; i < 4; i++) m_exp[i] = 0;
    endtask

    task automatic model_edge(input logic v, input logic [TW-1:0] d);
        logic [15:0] seq;
        logic [7:0]  src;
        logic [31:0] lat;
        logic [63:0] s;
        if (v) begin
            seq = d[2 +: 16];
            src = d[18 +: 8];
            lat = m_cnt - d[26 +: 32];
            if (d[0] != 1'b0 || d[1] != 1'b0 || src >= 8'd4) m_addr = 1;
            if (src < 8'd4) begin
                if (seq != m_exp[src[1:0]]) m_seq = 1;
                m_exp[src[1:0]] = seq + 16'd1;
            end
            if (lat > m_lmax) m_lmax = lat;
            s = 64'(m_lsum) + 64'(lat);
            m_lsum = (s > 64'hFFFF_FFFF_FFFF) ? 48'hFFFF_FFFF_FFFF : s[47:0];
            for (int k = 0; k < 3; k++) begin
                if (m_edges >= 1 && m_rx >= 32'(n_exp[k])) m_ovf[k] = 1;
            end
            m_rx = m_rx + 1;
        end
        m_cnt = m_cnt + 1;
        m_edges++;
    endtask

    function automatic logic m_done(input int n);
        return (m_edges >= 1) && (m_rx >= 32'(n));
    endfunction

    task automatic check_all(input string ph);
        check_eq({ph, ".rx_a"},   rxc_a,   m_rx);
        check_eq({ph, ".lmax_a"}, lmax_a,  m_lmax);
        check_eq({ph, ".lsum_a"}, lsum_a,  m_lsum);
        check_eq({ph, ".flags_a"}, flags_a, {m_ovf[0], m_seq, m_addr});
        check_eq({ph, ".err_a"},  err_a,   m_ovf[0] | m_seq | m_addr);
        check_eq({ph, ".done_a"}, done_a,  m_done(NA));
        check_eq({ph, ".rx_b"},   rxc_b,   m_rx);
        check_eq({ph, ".flags_b"}, flags_b, {m_ovf[1], m_seq, m_addr});
        check_eq({ph, ".done_b"}, done_b,  m_done(NB));
        check_eq({ph, ".flags_c"}, flags_c, {m_ovf[2], m_seq, m_addr});
        check_eq({ph, ".done_c"}, done_c,  m_done(NC));
    endtask

    task automatic step(input string ph, input logic v, input logic [TW-1:0] d);
        @(negedge clk);
        rx_if.i_valid = v;
        rx_if.i_data  = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
        check_all(ph);
    endtask

    task automatic idle_until(input logic [31:0] c);
        for (int i = 0; i < 1000 && m_cnt != c; i++) step("idle", 1'b0, '0);
        check_eq("idle_until", m_cnt, c);
    endtask

    // Asserts reset wherever the bench currently is and releases it just after an edge.
    task automatic do_reset();
        rstn = 1'b0;
        rx_if.i_valid = 1'b0;
        #1;
        check_eq("rst.rx",    rxc_a,   0);
        check_eq("rst.flags", flags_a, 0);
        check_eq("rst.lmax",  lmax_a,  0);
        check_eq("rst.lsum",  lsum_a,  0);
        check_eq("rst.done_c", done_c, 0);
        model_reset();
        check_all("rst");
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    initial begin
        logic [7:0]  src;
        logic [15:0] seq;
        rx_if.i_valid = 1'b0;
        rx_if.i_data  = '0;
        model_reset();
        #3;
        do_reset();

        idle_until(20);
        for (int i = 0; i < 3; i++) step("t1", 1'b1, mk(0, 0, 8'd1, 16'(i), 32'(10 + i)));
        check_eq("t1.rx", rxc_a, 3);
        check_eq("t1.lmax", lmax_a, 10);
        check_eq("t1.lsum", lsum_a, 30);
        check_eq("t1.err", err_a, 0);

        do_reset();
        idle_until(5);
        step("wrap", 1'b1, mk(0, 0, 8'd0, 16'd0, 32'hFFFF_FFF0));
        check_eq("wrap.lmax", lmax_a, 21);
        step("dx", 1'b1, mk(1, 0, 8'd0, 16'd1, m_cnt - 3));
        check_eq("dx.flags", flags_a, 3'b001);
        check_eq("dx.rx", rxc_a, 2);

        do_reset();
        step("seq", 1'b1, mk(0, 0, 8'd2, 16'd0, m_cnt));
        step("seq", 1'b1, mk(0, 0, 8'd2, 16'd2, m_cnt));
        check_eq("seq.gap", flags_a, 3'b010);
        step("seq", 1'b1, mk(0, 0, 8'd2, 16'd3, m_cnt));
        check_eq("seq.resync", flags_a, 3'b010);
        step("seq", 1'b1, mk(0, 0, 8'd3, 16'd0, m_cnt));
        check_eq("seq.other", flags_a, 3'b010);

        do_reset();
        for (int i = 0; i < 3; i++) step("n4", 1'b1, mk(0, 0, 8'd3, 16'(i), m_cnt - 1));
        check_eq("n4.not_done", done_b, 0);
        step("n4", 1'b1, mk(0, 0, 8'd3, 16'd3, m_cnt - 1));
        check_eq("n4.done", done_b, 1);
        check_eq("n4.no_ovf", flags_b, 3'b000);
        step("n4", 1'b1, mk(0, 0, 8'd3, 16'd4, m_cnt - 1));
        check_eq("n4.ovf", flags_b, 3'b100);
        check_eq("n4.rx", rxc_b, 5);

        do_reset();
        step("mid", 1'b1, mk(0, 0, 8'd0, 16'd0, m_cnt));
        step("mid", 1'b1, mk(0, 0, 8'd0, 16'd1, m_cnt));
        do_reset();
        step("mid", 1'b1, mk(0, 0, 8'd0, 16'd0, m_cnt));
        check_eq("mid.restart", flags_a, 3'b000);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            src = ($urandom_range(0, 15) == 0) ? 8'(4 + $urandom_range(0, 200)) : 8'($urandom_range(0, 3));
            seq = ($urandom_range(0, 7) == 0) ? 16'($urandom) : m_exp[src[1:0]];
            step("rnd", $urandom_range(0, 3) != 0,
                 mk($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, src, seq,
                    m_cnt - 32'($urandom_range(0, 600))));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
